// File: rtl/ps2_pkg.sv
// Shared constants, event word layout and parser state encoding for the PS/2 set-2 decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;
    localparam logic [7:0] PS2_BAT   = 8'hAA;
    localparam logic [7:0] PS2_ACK   = 8'hFA;
    localparam logic [7:0] PS2_ECHO  = 8'hEE;
    localparam logic [7:0] PS2_FAIL  = 8'hFC;
    localparam logic [7:0] PS2_OVR0  = 8'h00;
    localparam logic [7:0] PS2_OVR1  = 8'hFF;

    localparam logic [7:0] MOD_LSHIFT = 8'h12;
    localparam logic [7:0] MOD_RSHIFT = 8'h59;
    localparam logic [7:0] MOD_CTRL   = 8'h14;
    localparam logic [7:0] MOD_ALT    = 8'h11;
    localparam logic [7:0] FAKE_SHIFT = 8'h12;
    localparam logic [7:0] PAUSE_CODE = 8'h77;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } key_event_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXTBRK,
        ST_PAUSE
    } ps2_state_e;

    // Keyboard status / housekeeping bytes that carry no key information.
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_ECHO) ||
               (b == PS2_FAIL) || (b == PS2_OVR0) || (b == PS2_OVR1);
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Generic synchronous valid/ready FIFO; head word reads as zero while empty.
module event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop, w_wr;

    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign w_pop   = o_valid && i_ready;
    // A pop in the same cycle frees the slot, so a push while full is still taken.
    assign w_wr    = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_decoder.sv
// Turns the raw PS/2 set-2 byte stream into make/break key events, tracks modifier
// levels, and queues events behind a valid/ready FIFO with overflow accounting.
module ps2_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       valid_in,
    input  logic [7:0] scancode_in,
    input  logic       error_in,
    output logic       event_valid_out,
    input  logic       event_ready_in,
    output logic [9:0] event_out,
    output logic [2:0] mods_out,
    output logic       overflow_out,
    output logic [7:0] drop_count_out
);
    logic [1:0]  r_rst_sync;
    logic        w_rst_n;
    ps2_state_e  r_state;
    logic [2:0]  r_skip;
    logic [5:0]  r_mod_bits;   // {ralt, lalt, rctrl, lctrl, rshift, lshift}
    logic        w_push, w_full, w_pop, w_drop;
    key_event_t  w_evt;

    // Assert asynchronously, release two clocks later.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_rst_sync <= 2'b00;
        else         r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    always_comb begin
        w_push = 1'b0;
        w_evt  = '0;
        if (valid_in && !error_in) begin
            case (r_state)
                ST_IDLE: if (scancode_in != PS2_EXT && scancode_in != PS2_BRK &&
                             scancode_in != PS2_PAUSE && !is_ignored(scancode_in)) begin
                    w_push = 1'b1;
                    w_evt  = '{brk: 1'b0, ext: 1'b0, code: scancode_in};
                end
                ST_EXT: if (scancode_in != PS2_BRK && scancode_in != FAKE_SHIFT) begin
                    w_push = 1'b1;
                    w_evt  = '{brk: 1'b0, ext: 1'b1, code: scancode_in};
                end
                ST_BRK: begin
                    w_push = 1'b1;
                    w_evt  = '{brk: 1'b1, ext: 1'b0, code: scancode_in};
                end
                ST_EXTBRK: if (scancode_in != FAKE_SHIFT) begin
                    w_push = 1'b1;
                    w_evt  = '{brk: 1'b1, ext: 1'b1, code: scancode_in};
                end
                ST_PAUSE: if (r_skip == 3'd1) begin
                    w_push = 1'b1;
                    w_evt  = '{brk: 1'b0, ext: 1'b1, code: PAUSE_CODE};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
            r_skip  <= '0;
        end else if (error_in) begin
            r_state <= ST_IDLE;
            r_skip  <= '0;
        end else if (valid_in) begin
            case (r_state)
                ST_IDLE: begin
                    if (scancode_in == PS2_EXT)        r_state <= ST_EXT;
                    else if (scancode_in == PS2_BRK)   r_state <= ST_BRK;
                    else if (scancode_in == PS2_PAUSE) begin
                        r_state <= ST_PAUSE;
                        r_skip  <= PAUSE_SKIP;
                    end
                end
                ST_EXT:  r_state <= (scancode_in == PS2_BRK) ? ST_EXTBRK : ST_IDLE;
                ST_PAUSE: begin
                    if (r_skip == 3'd1) begin
                        r_state <= ST_IDLE;
                        r_skip  <= '0;
                    end else begin
                        r_skip  <= r_skip - 3'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_mod_bits <= '0;
        end else if (w_push) begin
            case ({w_evt.ext, w_evt.code})
                {1'b0, MOD_LSHIFT}: r_mod_bits[0] <= !w_evt.brk;
                {1'b0, MOD_RSHIFT}: r_mod_bits[1] <= !w_evt.brk;
                {1'b0, MOD_CTRL}:   r_mod_bits[2] <= !w_evt.brk;
                {1'b1, MOD_CTRL}:   r_mod_bits[3] <= !w_evt.brk;
                {1'b0, MOD_ALT}:    r_mod_bits[4] <= !w_evt.brk;
                {1'b1, MOD_ALT}:    r_mod_bits[5] <= !w_evt.brk;
                default: ;
            endcase
        end
    end

    assign mods_out = {r_mod_bits[5] | r_mod_bits[4],
                       r_mod_bits[3] | r_mod_bits[2],
                       r_mod_bits[1] | r_mod_bits[0]};

    assign w_pop  = event_valid_out && event_ready_in;
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk_in or negedge w_rst_n) begin
        if (!w_rst_n) begin
            overflow_out   <= 1'b0;
            drop_count_out <= '0;
        end else if (w_drop) begin
            overflow_out <= 1'b1;
            if (drop_count_out != 8'hFF) drop_count_out <= drop_count_out + 8'd1;
        end
    end

    event_fifo #(
        .WIDTH (10),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_in),
        .rst_n   (w_rst_n),
        .i_push  (w_push),
        .i_data  (w_evt),
        .i_ready (event_ready_in),
        .o_valid (event_valid_out),
        .o_data  (event_out),
        .o_full  (w_full)
    );

endmodule

// File: tb/tb_ps2_decoder.sv
// Directed self-checking bench for ps2_decoder: framing, extended/break/pause parsing,
// modifiers, error recovery and FIFO overflow behaviour.
module tb_ps2_decoder;
    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       valid_in;
    logic [7:0] scancode_in;
    logic       error_in;
    logic       event_valid_out;
    logic       event_ready_in;
    logic [9:0] event_out;
    logic [2:0] mods_out;
    logic       overflow_out;
    logic [7:0] drop_count_out;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_in = ~clk_in;

    ps2_decoder #(.DEPTH(8)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .valid_in        (valid_in),
        .scancode_in     (scancode_in),
        .error_in        (error_in),
        .event_valid_out (event_valid_out),
        .event_ready_in  (event_ready_in),
        .event_out       (event_out),
        .mods_out        (mods_out),
        .overflow_out    (overflow_out),
        .drop_count_out  (drop_count_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge; leaves the bench at the negedge after the byte was clocked in.
    task automatic send(input logic [7:0] b);
        valid_in    = 1'b1;
        scancode_in = b;
        @(negedge clk_in);
        valid_in    = 1'b0;
    endtask

    task automatic pop_check(input logic [9:0] exp, input string tag);
        check({tag, "_valid"}, 32'(event_valid_out), 32'd1);
        check({tag, "_data"},  32'(event_out), 32'(exp));
        event_ready_in = 1'b1;
        @(negedge clk_in);
        event_ready_in = 1'b0;
    endtask

    initial begin
        rst_in = 1'b0; valid_in = 1'b0; scancode_in = 8'h00;
        error_in = 1'b0; event_ready_in = 1'b0;
        repeat (2) @(negedge clk_in);
        check("rst_valid", 32'(event_valid_out), 32'd0);
        check("rst_event", 32'(event_out), 32'd0);
        check("rst_mods",  32'(mods_out), 32'd0);
        check("rst_ovf",   32'(overflow_out), 32'd0);
        check("rst_drop",  32'(drop_count_out), 32'd0);
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);

        // Plain make: head appears one cycle after the strobe.
        valid_in = 1'b1; scancode_in = 8'h1C;
        #1 check("lat_pre", 32'(event_valid_out), 32'd0);
        @(negedge clk_in);
        valid_in = 1'b0;
        check("lat_post", 32'(event_valid_out), 32'd1);
        pop_check(10'h01C, "make_1c");
        send(8'hF0); send(8'h1C);
        pop_check(10'h21C, "brk_1c");
        check("empty1", 32'(event_valid_out), 32'd0);

        // Extended make/break and fake shifts.
        send(8'hE0); send(8'h75);
        pop_check(10'h175, "ext_make");
        send(8'hE0); send(8'hF0); send(8'h75);
        pop_check(10'h375, "ext_brk");
        send(8'hE0); send(8'h12);
        send(8'hE0); send(8'hF0); send(8'h12);
        check("fake_shift_none", 32'(event_valid_out), 32'd0);

        // Pause sequence yields one event, then parser is back in IDLE.
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        pop_check(10'h177, "pause");
        check("pause_single", 32'(event_valid_out), 32'd0);
        send(8'h1C);
        pop_check(10'h01C, "post_pause");

        // Modifiers.
        send(8'h12);
        check("mods_lshift", 32'(mods_out), 32'd1);
        send(8'hE0); send(8'h14);
        check("mods_rctrl", 32'(mods_out), 32'd3);
        send(8'hF0); send(8'h12);
        check("mods_shift_up", 32'(mods_out), 32'd2);
        send(8'hE0); send(8'hF0); send(8'h14);
        check("mods_clear", 32'(mods_out), 32'd0);
        pop_check(10'h012, "mod_ev0");
        pop_check(10'h114, "mod_ev1");
        pop_check(10'h212, "mod_ev2");
        pop_check(10'h314, "mod_ev3");

        // Error recovery and ignored bytes.
        send(8'hE0);
        error_in = 1'b1;
        @(negedge clk_in);
        error_in = 1'b0;
        send(8'h1C);
        pop_check(10'h01C, "err_recover");
        check("err_single", 32'(event_valid_out), 32'd0);
        error_in = 1'b1;
        send(8'h1C);
        error_in = 1'b0;
        check("err_wins", 32'(event_valid_out), 32'd0);
        send(8'hAA); send(8'hFA); send(8'h00);
        check("ignored", 32'(event_valid_out), 32'd0);
        check("no_ovf_yet", 32'(overflow_out), 32'd0);

        // Overflow: ten back-to-back makes into an 8-deep FIFO.
        for (int i = 1; i <= 10; i++) begin
            valid_in = 1'b1; scancode_in = 8'(i);
            @(negedge clk_in);
        end
        valid_in = 1'b0;
        check("ovf_flag", 32'(overflow_out), 32'd1);
        check("ovf_drop", 32'(drop_count_out), 32'd2);
        check("ovf_head", 32'(event_out), 32'h001);
        // Push and pop together while full: accepted, nothing dropped.
        valid_in = 1'b1; scancode_in = 8'h0B; event_ready_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0; event_ready_in = 1'b0;
        check("full_pushpop_drop", 32'(drop_count_out), 32'd2);
        for (int i = 2; i <= 8; i++) pop_check(10'(i), "drain");
        pop_check(10'h00B, "drain_last");
        check("drain_empty", 32'(event_valid_out), 32'd0);
        check("ovf_sticky", 32'(overflow_out), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ps2_decoder.md
# ps2_decoder

Converts the raw PS/2 set-2 byte stream from `ps2_rx` into whole key events. Each event is a make or break code with an extended flag, and events are buffered in a small FIFO behind a valid/ready handshake. It sits directly downstream of `ps2_rx` in the `clk_100mhz` domain and replaces the ad-hoc scancode shift register in the top level. It also tracks live modifier state for consumers such as the text/video path.

## Interface
- `DEPTH`, 8: event FIFO depth, power of two, ≥2.
- `clk_in` input 1: system clock (`clk_100mhz`).
- `rst_in` input 1: reset, asynchronous, active-low.
- `valid_in` input 1: one-cycle strobe; `scancode_in` is valid.
- `scancode_in` input 8: byte from `ps2_rx`.
- `error_in` input 1: one-cycle strobe for a framing/parity error from `ps2_rx`.
- `event_valid_out` output 1: FIFO head is valid.
- `event_ready_in` input 1: consumer accepts the head.
- `event_out` output 10: {brk, ext, code[7:0]}.
- `mods_out` output 3: {alt, ctrl, shift}, level state.
- `overflow_out` output 1: sticky; an event was dropped because the FIFO was full.
- `drop_count_out` output 8: saturating count of dropped events.

## Operation
- Parser FSM states and transitions (all advance only on `valid_in`):
  - IDLE:
    - E0 → EXT
    - F0 → BRK
    - E1 → PAUSE (skip counter = 7)
    - AA, FA, EE, FC (BAT, ACK, echo, fail) → ignored
    - 00, FF (keyboard overrun) → ignored
    - any other byte → emit {0,0,b}
  - EXT:
    - F0 → EXTBRK
    - 12 (fake shift) → discard, go to IDLE
    - otherwise emit {0,1,b}, go to IDLE
  - BRK: emit {1,0,b}, go to IDLE.
  - EXTBRK:
    - 12 → discard, go to IDLE
    - otherwise emit {1,1,b}, go to IDLE
  - PAUSE: decrement on each byte; on the 7th byte emit {0,1,77}, go to IDLE. Byte values inside PAUSE are not checked.
- `error_in` in any state forces IDLE and discards the partial sequence; nothing is emitted. If `error_in` and `valid_in` are asserted together, the error wins and the byte is dropped.
- Modifiers update on the same cycle as their emit:
  - shift = L (12) OR R (59).
  - ctrl = L (14) OR R (E0 14).
  - alt = L (11) OR R (E0 11).
  - Make sets the per-key bit and break clears it. Modifier events are also pushed to the FIFO.
- FIFO write and read rules:
  - The parser pushes; a pop occurs when `event_valid_out && event_ready_in`.
  - Push while full with no pop: the event is dropped, `overflow_out` is set, and `drop_count_out` increments, saturating at 255.
  - Push and pop in the same cycle while full: the push is accepted and the count is unchanged.
  - Push and pop in the same cycle while empty: the push is accepted and appears next cycle; no bypass.
  - Occupancy counter width is clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- `event_out` holds the head word while `event_valid_out` is high and stays stable until popped.

## Timing
- Reset values, applied asynchronously on `rst_in`=0:
  - parser in IDLE, skip counter 0
  - FIFO empty
  - `event_valid_out` 0, `event_out` 0
  - `mods_out` 0, `overflow_out` 0, `drop_count_out` 0
- Latency: the final byte's `valid_in` at cycle N produces the push at the N+1 clock edge. `event_valid_out` goes high in cycle N+1 if the FIFO was empty. `mods_out` changes in cycle N+1.
- Throughput: one byte per cycle is accepted, well beyond the ~1 byte per 1.1 ms PS/2 rate.
- Reset mid-sequence: the partial sequence is lost. Reset release is synchronised internally (2-flop deassert).
- `event_ready_in` may be held high permanently. The FIFO sustains one pop per cycle.

## Structure
- `ps2_pkg`: byte constants (`PS2_EXT`=E0, `PS2_BRK`=F0, `PS2_PAUSE`=E1, `PS2_BAT`=AA, `PS2_ACK`=FA, `PS2_ECHO`=EE, `PS2_FAIL`=FC), modifier codes, `key_event_t` packed struct {brk, ext, code}, and the parser state enum.
- Sub-module `event_fifo`: a generic synchronous valid/ready FIFO with parameters WIDTH and DEPTH, and a full flag. The parser and modifier logic stay in `ps2_decoder`.

## Test plan
- Bytes 1C, then F0 1C → events 0x01C then 0x21C. `event_valid_out` rises 1 cycle after the 1C strobe.
- E0 75, then E0 F0 75 → events 0x175 and 0x375. E0 12 and E0 F0 12 produce no events.
- E1 14 77 E1 F0 14 F0 77 → exactly one event, 0x177. The parser ends in IDLE, verified by a following 1C → 0x01C.
- 12 (make), then E0 14 (make) → `mods_out`=3'b011. F0 12 → 3'b010. Then E0 F0 14 → 3'b000.
- E0, then `error_in`, then 1C → single event 0x01C. AA, FA and 00 alone → no events.
- `event_ready_in`=0, ten make codes 01..0A → FIFO holds 01..08, `overflow_out`=1, `drop_count_out`=2. Then `ready`=1 → 8 pops in order. A push in the same cycle as a pop while full is accepted without loss.
